// File: rtl/riscv_pkg.sv
// riscv_pkg: shared ALU op codes and default widths for the execute stage
package riscv_pkg;
   localparam int DEF_XLEN   = 32;
   localparam int DEF_REG_AW = 5;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU; undefined codes give result 0 and flag illegal
module alu_core
   import riscv_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);
   localparam int SW = $clog2(XLEN);
   logic [SW-1:0] shamt;
   assign shamt = op_b[SW-1:0];
   always_comb begin
      result  = '0;
      illegal = 1'b0;
      case (alu_ctrl)
         ALU_ADD:  result = op_a + op_b;
         ALU_SUB:  result = op_a - op_b;
         ALU_AND:  result = op_a & op_b;
         ALU_OR:   result = op_a | op_b;
         ALU_XOR:  result = op_a ^ op_b;
         ALU_SLL:  result = op_a << shamt;
         ALU_SRL:  result = op_a >> shamt;
         ALU_SRA:  result = $signed(op_a) >>> shamt;
         ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         ALU_SLTU: result = {{(XLEN-1){1'b0}}, op_a < op_b};
         default:  illegal = 1'b1;
      endcase
   end
   assign zero = (result == '0);
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage computing ALU result and branch decision into the
// EX/MEM register; flush beats stall beats load
module ex_stage
   import riscv_pkg::*;
#(
   parameter int XLEN   = DEF_XLEN,
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [3:0]        alu_ctrl,
   input  logic [XLEN-1:0]   op_a,
   input  logic [XLEN-1:0]   op_b,
   input  logic [XLEN-1:0]   store_data,
   input  logic [REG_AW-1:0] rd,
   input  logic              reg_write,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              is_branch,
   input  logic [XLEN-1:0]   branch_target,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   output logic [XLEN-1:0]   alu_result,
   output logic              zero,
   output logic [XLEN-1:0]   out_store_data,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_reg_write,
   output logic              out_mem_read,
   output logic              out_mem_write,
   output logic              branch_taken,
   output logic [XLEN-1:0]   out_branch_target,
   output logic              illegal_op
);
   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   result;
      logic              zero;
      logic [XLEN-1:0]   store_data;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              taken;
      logic [XLEN-1:0]   target;
      logic              illegal;
   } ex_mem_t;

   ex_mem_t         ex_mem_q, ex_mem_d;
   logic [XLEN-1:0] alu_res;
   logic            alu_zero, alu_illegal, side_ok;

   alu_core #(.XLEN(XLEN)) u_alu (
      .alu_ctrl (alu_ctrl),
      .op_a     (op_a),
      .op_b     (op_b),
      .result   (alu_res),
      .zero     (alu_zero),
      .illegal  (alu_illegal)
   );

   // undefined ops still propagate but must not write anything or redirect
   assign side_ok = in_valid & ~alu_illegal;

   always_comb begin
      ex_mem_d = ex_mem_q;
      if (flush) begin
         ex_mem_d.valid     = 1'b0;
         ex_mem_d.reg_write = 1'b0;
         ex_mem_d.mem_read  = 1'b0;
         ex_mem_d.mem_write = 1'b0;
         ex_mem_d.taken     = 1'b0;
         ex_mem_d.illegal   = 1'b0;
      end else if (!stall) begin
         ex_mem_d.valid      = in_valid;
         ex_mem_d.result     = alu_res;
         ex_mem_d.zero       = alu_zero;
         ex_mem_d.store_data = store_data;
         ex_mem_d.rd         = rd;
         ex_mem_d.reg_write  = side_ok & reg_write;
         ex_mem_d.mem_read   = side_ok & mem_read;
         ex_mem_d.mem_write  = side_ok & mem_write;
         ex_mem_d.taken      = side_ok & is_branch & alu_zero;
         ex_mem_d.target     = branch_target;
         ex_mem_d.illegal    = in_valid & alu_illegal;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ex_mem_q <= '0;
      else     ex_mem_q <= ex_mem_d;
   end

   assign out_valid         = ex_mem_q.valid;
   assign alu_result        = ex_mem_q.result;
   assign zero              = ex_mem_q.zero;
   assign out_store_data    = ex_mem_q.store_data;
   assign out_rd            = ex_mem_q.rd;
   assign out_reg_write     = ex_mem_q.reg_write;
   assign out_mem_read      = ex_mem_q.mem_read;
   assign out_mem_write     = ex_mem_q.mem_write;
   assign branch_taken      = ex_mem_q.taken;
   assign out_branch_target = ex_mem_q.target;
   assign illegal_op        = ex_mem_q.illegal;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed checks of ex_stage ALU ops, branch, stall/flush, illegal and reset
module tb_ex_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [3:0]  alu_ctrl = '0;
   logic [31:0] op_a = '0, op_b = '0, store_data = '0, branch_target = '0;
   logic [4:0]  rd = '0;
   logic        reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0, is_branch = 1'b0;
   logic        stall = 1'b0, flush = 1'b0;
   logic        out_valid, zero, out_reg_write, out_mem_read, out_mem_write, branch_taken, illegal_op;
   logic [31:0] alu_result, out_store_data, out_branch_target;
   logic [4:0]  out_rd;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .alu_ctrl(alu_ctrl),
      .op_a(op_a), .op_b(op_b), .store_data(store_data), .rd(rd),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .is_branch(is_branch), .branch_target(branch_target),
      .stall(stall), .flush(flush), .out_valid(out_valid),
      .alu_result(alu_result), .zero(zero), .out_store_data(out_store_data),
      .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write), .branch_taken(branch_taken),
      .out_branch_target(out_branch_target), .illegal_op(illegal_op)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      alu_ctrl = c;
      op_a     = a;
      op_b     = b;
   endtask

   task automatic test_reset();
      step();
      total++; if ({out_valid, zero, out_reg_write, out_mem_read, out_mem_write, branch_taken, illegal_op, out_rd} !== 12'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", {out_valid, zero, out_reg_write, out_mem_read, out_mem_write, branch_taken, illegal_op, out_rd}); end
      total++; if ({alu_result, out_store_data, out_branch_target} !== 96'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {alu_result, out_store_data, out_branch_target}); end
      rst = 1'b0;
   endtask

   task automatic test_add_wrap();
      drive(4'd0, 32'hFFFF_FFFF, 32'h1);
      reg_write = 1'b1; mem_write = 1'b1; rd = 5'd5; store_data = 32'hDEAD_BEEF;
      step();
      total++; if (alu_result !== 32'h0) begin bad++; $display("FAIL add_wrap_res got=%h exp=00000000", alu_result); end
      total++; if ({out_valid, zero} !== 2'b11) begin bad++; $display("FAIL add_wrap_vz got=%b exp=11", {out_valid, zero}); end
      total++; if ({out_rd, out_reg_write, out_mem_write, out_mem_read} !== {5'd5, 3'b110}) begin bad++; $display("FAIL add_ctrl got=%h exp=%h", {out_rd, out_reg_write, out_mem_write, out_mem_read}, {5'd5, 3'b110}); end
      total++; if (out_store_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL add_store got=%h exp=deadbeef", out_store_data); end
      reg_write = 1'b0; mem_write = 1'b0;
   endtask

   task automatic test_branch();
      drive(4'd1, 32'h5, 32'h5);
      is_branch = 1'b1; branch_target = 32'h100;
      step();
      total++; if ({branch_taken, out_branch_target} !== {1'b1, 32'h100}) begin bad++; $display("FAIL beq_taken got=%b/%h exp=1/00000100", branch_taken, out_branch_target); end
      op_b = 32'h6;
      step();
      total++; if ({branch_taken, alu_result} !== {1'b0, 32'hFFFF_FFFF}) begin bad++; $display("FAIL beq_not got=%b/%h exp=0/ffffffff", branch_taken, alu_result); end
      is_branch = 1'b0;
   endtask

   task automatic test_shifts();
      drive(4'd7, 32'h8000_0000, 32'h24);
      step();
      total++; if (alu_result !== 32'hF800_0000) begin bad++; $display("FAIL sra got=%h exp=f8000000", alu_result); end
      alu_ctrl = 4'd6;
      step();
      total++; if (alu_result !== 32'h0800_0000) begin bad++; $display("FAIL srl got=%h exp=08000000", alu_result); end
      alu_ctrl = 4'd5;
      step();
      total++; if ({alu_result, zero} !== {32'h0, 1'b1}) begin bad++; $display("FAIL sll got=%h/%b exp=00000000/1", alu_result, zero); end
      drive(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00);
      step();
      total++; if (alu_result !== 32'h0FF0_0FF0) begin bad++; $display("FAIL xor got=%h exp=0ff00ff0", alu_result); end
   endtask

   task automatic test_slt();
      drive(4'd8, 32'hFFFF_FFFF, 32'h1);
      step();
      total++; if (alu_result !== 32'h1) begin bad++; $display("FAIL slt got=%h exp=00000001", alu_result); end
      alu_ctrl = 4'd9;
      step();
      total++; if ({alu_result, zero} !== {32'h0, 1'b1}) begin bad++; $display("FAIL sltu got=%h/%b exp=00000000/1", alu_result, zero); end
   endtask

   task automatic test_stall_flush();
      drive(4'd0, 32'h1, 32'h2);
      reg_write = 1'b1;
      step();
      total++; if ({alu_result, out_reg_write} !== {32'h3, 1'b1}) begin bad++; $display("FAIL load3 got=%h/%b exp=00000003/1", alu_result, out_reg_write); end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(4'd2, 32'h7 + i, 32'hFF);
         reg_write = 1'b0;
         step();
         total++; if ({out_valid, alu_result, out_reg_write} !== {1'b1, 32'h3, 1'b1}) begin bad++; $display("FAIL stall_hold%0d got=%b/%h/%b exp=1/00000003/1", i, out_valid, alu_result, out_reg_write); end
      end
      flush = 1'b1;
      step();
      total++; if ({out_valid, out_reg_write} !== 2'b00) begin bad++; $display("FAIL flush_stall got=%b exp=00", {out_valid, out_reg_write}); end
      flush = 1'b0; stall = 1'b0;
      drive(4'd3, 32'h10, 32'h01);
      in_valid = 1'b0; reg_write = 1'b1;
      step();
      total++; if ({out_valid, out_reg_write, alu_result} !== {2'b00, 32'h11}) begin bad++; $display("FAIL bubble got=%b/%b/%h exp=0/0/00000011", out_valid, out_reg_write, alu_result); end
   endtask

   task automatic test_illegal_reset();
      drive(4'hF, 32'h1234, 32'h5678);
      reg_write = 1'b1; mem_read = 1'b1; is_branch = 1'b1;
      step();
      total++; if ({alu_result, zero, illegal_op, out_valid} !== {32'h0, 3'b111}) begin bad++; $display("FAIL illegal_res got=%h/%b/%b/%b exp=0/1/1/1", alu_result, zero, illegal_op, out_valid); end
      total++; if ({out_reg_write, out_mem_read, branch_taken} !== 3'b000) begin bad++; $display("FAIL illegal_gate got=%b exp=000", {out_reg_write, out_mem_read, branch_taken}); end
      mem_read = 1'b0; is_branch = 1'b0;
      drive(4'd0, 32'h1, 32'h2);
      step();
      stall = 1'b1; flush = 1'b1; rst = 1'b1;
      #2;
      total++; if ({out_valid, zero, out_reg_write, illegal_op, alu_result} !== 36'h0) begin bad++; $display("FAIL async_rst got=%h exp=0", {out_valid, zero, out_reg_write, illegal_op, alu_result}); end
      step();
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      drive(4'd0, 32'h20, 32'h22);
      step();
      total++; if ({out_valid, alu_result, out_reg_write} !== {1'b1, 32'h42, 1'b1}) begin bad++; $display("FAIL post_rst got=%b/%h/%b exp=1/00000042/1", out_valid, alu_result, out_reg_write); end
   endtask

   initial begin
      test_reset();
      test_add_wrap();
      test_branch();
      test_shifts();
      test_slt();
      test_stall_flush();
      test_illegal_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ex_stage.md
# ex_stage

Registered execute stage of the in-order RISC-V pipeline. Sits directly downstream of the ALU control unit: consumes the 4-bit ALU operation code plus ID/EX operands and control bits, computes the ALU result and branch decision, and launches everything into the EX/MEM pipeline register with stall/flush handling. One-cycle latency, one operation per cycle.

## Interface
- XLEN, 32, datapath width; shift amount uses low log2(XLEN) bits of op_b
- REG_AW, 5, register index width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ID/EX slot holds a real instruction
- alu_ctrl  in  4  ALU op code from ALU control unit
- op_a, op_b  in  XLEN  forwarded operands (op_b already muxed with immediate)
- store_data  in  XLEN  rs2 value for stores
- rd  in  REG_AW  destination register
- reg_write, mem_read, mem_write, is_branch  in  1 each  control bits from ID/EX
- branch_target  in  XLEN  precomputed PC+imm
- stall  in  1  hold EX/MEM contents
- flush  in  1  insert bubble into EX/MEM
- out_valid  out  1  EX/MEM slot valid
- alu_result  out  XLEN  registered result
- zero  out  1  registered (result == 0)
- out_store_data, out_rd, out_reg_write, out_mem_read, out_mem_write  out  registered copies
- branch_taken  out  1  registered: valid branch with zero = 1
- out_branch_target  out  XLEN  registered copy of branch_target
- illegal_op  out  1  registered: valid instruction carried an undefined alu_ctrl

## Operation
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU (unsigned); 10–15 undefined.
- ADD/SUB modulo 2^XLEN, no overflow flag. SLT/SLTU yield 1 or 0 zero-extended to XLEN.
- SRA replicates op_a[XLEN-1]; SRL/SLL fill zeros; shift amount op_b[log2(XLEN)-1:0], upper bits ignored.
- Undefined code: result 0, zero 1, illegal_op = in_valid; instruction still propagates (side-effect bits forced 0: reg_write, mem_read, mem_write, branch_taken).
- Register update priority per edge: rst > flush > stall > load.
  - flush: out_valid, out_reg_write, out_mem_read, out_mem_write, branch_taken, illegal_op ← 0; data fields don't-care (hold allowed).
  - stall (no flush): every EX/MEM field holds.
  - load: all fields captured; control bits and branch_taken/illegal_op gated by in_valid.
- branch_taken = in_valid & is_branch & (result == 0) at capture (BEQ compare via SUB); BNE inversion handled upstream.

## Timing
- Latency 1 cycle: inputs at edge N appear on outputs after edge N+1; throughput 1/cycle when stall = 0.
- Reset (asynchronous assert, synchronous release to clk): all outputs 0, including alu_result and zero (zero resets to 0, not 1).
- Reset mid-stall or mid-flush: reset wins immediately; first post-reset edge loads normally if stall/flush low.
- flush and stall both high: bubble inserted (flush wins).
- in_valid = 0 with stall = 0: bubble loaded, out_valid = 0.
- No combinational path from inputs to outputs.

## Structure
- Shared package riscv_pkg: ALU op code constants (ALU_ADD … ALU_SLTU), XLEN and REG_AW defaults, EX/MEM field struct if the flow allows packed structs.
- Sub-module alu_core: purely combinational, (alu_ctrl, op_a, op_b) → (result, zero, illegal); ex_stage adds gating and the EX/MEM register.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001 -> next cycle alu_result 0x00000000, zero 1, out_valid 1.
- SUB 0x00000005 − 0x00000005 with is_branch 1, branch_target 0x00000100 -> branch_taken 1, out_branch_target 0x00000100; same with op_b 0x6 -> branch_taken 0, result 0xFFFFFFFF.
- op_a 0x80000000, op_b 0x00000024 (shamt 4): SRA -> 0xF8000000, SRL -> 0x08000000, SLL -> 0x00000000 zero 1.
- op_a 0xFFFFFFFF, op_b 0x00000001: SLT -> 1, SLTU -> 0.
- Load ADD 1+2 (result 3, reg_write 1), stall 3 cycles while inputs change -> outputs hold 3; flush + stall together -> out_valid 0, out_reg_write 0.
- alu_ctrl 4'b1111 with in_valid 1, reg_write 1 -> result 0, illegal_op 1, out_reg_write 0; assert rst mid-stream -> all outputs 0 without clock edge.
